// File: rtl/gamma_pkg.sv
// -----------------------------------------------------------------------------
// gamma_pkg
// Shared definitions for the gamma-cycle spike sequencer.
//   T_W_DEF    : default spike-time width
//   t_inf()    : "no spike" code for a given width (all ones)
//   gamma_len(): number of RUN cycles in one gamma cycle
//   state_t    : sequencer state encoding (IDLE/SET/RUN/DONE)
//   IDLE_LVL   : resting level of the a/b lines and inactive level of y
// Build option: FALLING_EDGE_EN -- lines idle high, spikes are falling edges,
// y is active-low. Undefined (default): idle low, rising edges, y active-high.
// -----------------------------------------------------------------------------
package gamma_pkg;

    localparam int T_W_DEF = 4;

    // All-ones code means "this line never spikes".
    function automatic int t_inf(input int tw);
        return (1 << tw) - 1;
    endfunction

    // One RUN cycle for every representable finite spike time (0..T_INF-1).
    function automatic int gamma_len(input int tw);
        return t_inf(tw);
    endfunction

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SET  = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

`ifdef FALLING_EDGE_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    localparam logic ACTIVE_LVL = ~IDLE_LVL;

endpackage

// File: rtl/gamma_sequencer_edge_gen.sv
// -----------------------------------------------------------------------------
// edge_gen
// Produces one registered, polarity-aware spike line for the sequencer.
// The line is computed from the count the sequencer will hold in the next
// cycle, so the registered output lines up exactly with that count.
// Ports:
//   aclk, grst : clock, asynchronous active-high reset
//   cnt        : gamma count of the upcoming cycle
//   t          : spike time for this line (all ones = never spikes)
//   run        : upcoming cycle is a RUN cycle -> evaluate cnt >= t
//   clear      : upcoming cycle is SET -> return line to idle level
//   line       : registered line output (idle or active level)
// Build option: FALLING_EDGE_EN (via gamma_pkg::IDLE_LVL).
// -----------------------------------------------------------------------------
module edge_gen
    import gamma_pkg::*;
#(
    parameter int T_W = T_W_DEF
) (
    input  logic           aclk,
    input  logic           grst,
    input  logic [T_W-1:0] cnt,
    input  logic [T_W-1:0] t,
    input  logic           run,
    input  logic           clear,
    output logic           line
);

    localparam logic [T_W-1:0] T_INF = T_W'(t_inf(T_W));

    logic fire;

    // Once cnt reaches t the line stays active for the rest of the gamma
    // cycle, since cnt only increases; this keeps the line monotonic.
    assign fire = (t != T_INF) && (cnt >= t);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            line <= IDLE_LVL;
        end else if (clear) begin
            line <= IDLE_LVL;
        end else if (run) begin
            line <= fire ? ACTIVE_LVL : IDLE_LVL;
        end
        // otherwise hold: lines keep their final level through DONE/IDLE
    end

endmodule

// File: rtl/gamma_sequencer.sv
// -----------------------------------------------------------------------------
// gamma_sequencer
// Runs one gamma cycle per accepted job: pulses set to the not_equal
// datapath, drives spike lines a and b at their requested times, and records
// the first cycle in which the datapath result y is active.
// FSM: IDLE -> SET -> RUN (GAMMA_LEN cycles) -> DONE -> IDLE.
// Latency: counting the handshake cycle as cycle 0, out_valid is high in
// cycle GAMMA_LEN+2 (1 SET cycle plus GAMMA_LEN RUN cycles in between).
// Ports:
//   aclk, grst           : clock, asynchronous active-high reset
//   in_valid / in_ready  : job handshake (in_ready only in IDLE, no queueing)
//   ta, tb               : spike times for lines a, b (all ones = no spike)
//   set, a, b            : registered drive to the not_equal datapath
//   y                    : datapath result line
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   out_time             : first RUN count with y active, all ones if none
//   out_fired            : y was active at some point in the gamma cycle
// Build option: FALLING_EDGE_EN -- idle-high lines, falling-edge spikes,
// active-low y; timing unchanged.
// -----------------------------------------------------------------------------
module gamma_sequencer
    import gamma_pkg::*;
#(
    parameter int T_W = T_W_DEF
) (
    input  logic           aclk,
    input  logic           grst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [T_W-1:0] ta,
    input  logic [T_W-1:0] tb,
    output logic           set,
    output logic           a,
    output logic           b,
    input  logic           y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [T_W-1:0] out_time,
    output logic           out_fired
);

    localparam logic [T_W-1:0] T_INF    = T_W'(t_inf(T_W));
    localparam logic [T_W-1:0] CNT_LAST = T_W'(gamma_len(T_W) - 1);

    state_t         state;
    state_t         state_nxt;
    logic [T_W-1:0] cnt;
    logic [T_W-1:0] cnt_nxt;
    logic [T_W-1:0] ta_q;
    logic [T_W-1:0] tb_q;
    logic           accept;
    logic           y_act;
    logic           run_nxt;
    logic           set_nxt;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    // Normalise y so the capture logic only ever deals with "active".
    assign y_act = y ^ IDLE_LVL;

    // -------------------------------------------------------------------------
    // Next-state / next-count logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SET;
                end
            end
            ST_SET: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
            ST_RUN: begin
                // Stop on the last count instead of wrapping to zero.
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign run_nxt = (state_nxt == ST_RUN);
    assign set_nxt = (state_nxt == ST_SET);

    // -------------------------------------------------------------------------
    // State, count and job registers
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            ta_q <= T_INF;
            tb_q <= T_INF;
        end else if (accept) begin
            ta_q <= ta;
            tb_q <= tb;
        end
    end

    // set is registered from the next state so it is a clean one-cycle pulse
    // aligned with the SET state, free of decode glitches.
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            set <= 1'b0;
        end else begin
            set <= set_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Result capture: first active y in RUN wins, later activity is ignored.
    // During SET the datapath is being initialised, so y is not looked at.
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            out_time  <= T_INF;
            out_fired <= 1'b0;
        end else if (state == ST_SET) begin
            out_time  <= T_INF;
            out_fired <= 1'b0;
        end else if ((state == ST_RUN) && y_act && !out_fired) begin
            out_time  <= cnt;
            out_fired <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Spike lines. They are fed the upcoming count so that, in the RUN cycle
    // where cnt == k, each line already shows (k >= t).
    // -------------------------------------------------------------------------
    edge_gen #(
        .T_W (T_W)
    ) u_edge_a (
        .aclk  (aclk),
        .grst  (grst),
        .cnt   (cnt_nxt),
        .t     (ta_q),
        .run   (run_nxt),
        .clear (set_nxt),
        .line  (a)
    );

    edge_gen #(
        .T_W (T_W)
    ) u_edge_b (
        .aclk  (aclk),
        .grst  (grst),
        .cnt   (cnt_nxt),
        .t     (tb_q),
        .run   (run_nxt),
        .clear (set_nxt),
        .line  (b)
    );

endmodule

// File: doc/gamma_sequencer.md
GAMMA_SEQUENCER -- requirements
Module: gamma_sequencer

Interface
REQ-001 SHALL have parameter T_W, default 4, meaning spike-time width; derived T_INF = 2**T_W-1 (no spike), GAMMA_LEN = T_INF run cycles.
REQ-002 SHALL have port aclk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port grst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  job request.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept job.
REQ-006 SHALL have ports ta, tb  input  T_W each  spike times for lines a, b; T_INF = no spike.
REQ-007 SHALL have ports set, a, b  output  1 each  drive to the not_equal datapath.
REQ-008 SHALL have port y  input  1  datapath result line.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  result consumed.
REQ-011 SHALL have ports out_time (output, T_W, first cycle y seen active, T_INF if never) and out_fired (output, 1, y fired in gamma cycle).

Function
REQ-012 SHALL implement FSM IDLE -> SET -> RUN -> DONE -> IDLE.
REQ-013 SHALL in IDLE: in_ready=1; on in_valid&&in_ready edge latch ta/tb, go SET.
REQ-014 SHALL in SET: set=1 for exactly one cycle; a, b at idle level; y ignored; clear capture; cnt=0; go RUN.
REQ-015 SHALL in RUN cycle with cnt==k (k=0..GAMMA_LEN-1): a active iff k>=ta, b active iff k>=tb (registered outputs, glitch-free, monotonic within a gamma cycle).
REQ-016 SHALL in RUN: first cycle k in which y is active, capture out_time=k, out_fired=1; later activity ignored.
REQ-017 SHALL leave RUN after cnt==GAMMA_LEN-1, entering DONE; cnt never wraps.
REQ-018 SHALL in DONE: out_valid=1, out_time/out_fired stable until out_valid&&out_ready edge, then IDLE; a, b hold active levels until next SET.
REQ-019 SHALL deassert in_ready outside IDLE; in_valid then ignored, no queueing.
REQ-020 SHALL give latency accept edge -> out_valid high = GAMMA_LEN+2 cycles; same-cycle ta==tb both lines switch together; ta=T_INF line never switches.

Reset
REQ-021 SHALL on grst asynchronously force IDLE, set=0, a=b=idle level, out_valid=0, out_fired=0, out_time=T_INF, in_ready=1 once grst deasserted.
REQ-022 SHALL abort any job on reset mid-RUN/DONE with no result emitted.

Configuration
REQ-023 SHALL, without FALLING_EDGE_EN: idle level 0, spikes are rising edges, y active-high.
REQ-024 SHALL, with FALLING_EDGE_EN defined: idle level 1, spikes are falling edges, y active-low; timing identical.

Structure
REQ-025 SHALL place T_W default, T_INF/GAMMA_LEN derivation functions and state enum in shared package gamma_pkg.
REQ-026 SHALL instantiate sub-module edge_gen twice (a, b): inputs cnt, spike time, run/clear; output polarity-aware registered line.

Verification (bench closes loop with not_equal model: y active iff a!=b; T_W=4)
REQ-027 SHALL check ta=3, tb=7 -> a rises at cnt 3, out_time=3, out_fired=1, out_valid 17 cycles after accept.
REQ-028 SHALL check ta=5, tb=5 -> y never active, out_fired=0, out_time=15.
REQ-029 SHALL check ta=15, tb=9 -> a never switches, out_time=9, out_fired=1.
REQ-030 SHALL check out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored, then IDLE one cycle after handshake.
REQ-031 SHALL check grst pulse at cnt=6 of ta=2,tb=10 job -> immediate IDLE, a=b=idle, no out_valid; next job runs correctly.
REQ-032 SHALL rerun REQ-027..029 with FALLING_EDGE_EN -> same out_time, inverted line levels.
